// File: rtl/context_update_pkg.sv
// Shared definitions for the context update block.
//   - default widths used as parameter defaults by context_update / ctx_arith
//   - MIN_C / MAX_C limits of the bias-correction value C
//   - ctx_t: one context record {A, B, C, N} at the default widths
//   - ctx_state_e: initialisation FSM states (exposed on dbg_state)
package context_update_pkg;

  localparam int DEF_N_W = 7;
  localparam int DEF_A_W = 16;
  localparam int DEF_B_W = 16;
  localparam int DEF_C_W = 8;
  localparam int DEF_E_W = 9;

  // C limits; these match the default C_W of 8 bits.
  localparam int MIN_C = -128;
  localparam int MAX_C = 127;

  typedef struct packed {
    logic        [DEF_A_W-1:0] a;
    logic signed [DEF_B_W-1:0] b;
    logic signed [DEF_C_W-1:0] c;
    logic        [DEF_N_W-1:0] n;
  } ctx_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctx_state_e;

endpackage

// File: rtl/context_update_arith.sv
// ctx_arith: combinational JPEG-LS context update for one request.
//   in : a, b, c, n  -- stored context values
//        err         -- signed prediction error (Errval)
//   out: a_nxt, b_nxt, c_nxt, n_nxt -- post-update context values
//        halved      -- A, B and N were halved in this update
// All intermediate arithmetic is carried in 32-bit signed, wide enough for
// the default widths that it never overflows before the final truncation.
module ctx_arith
  import context_update_pkg::*;
#(
  parameter int N_W      = DEF_N_W,
  parameter int A_W      = DEF_A_W,
  parameter int B_W      = DEF_B_W,
  parameter int C_W      = DEF_C_W,
  parameter int E_W      = DEF_E_W,
  parameter int RESET_TH = 64,
  parameter int NEAR     = 0
) (
  input  logic        [A_W-1:0] a,
  input  logic signed [B_W-1:0] b,
  input  logic signed [C_W-1:0] c,
  input  logic        [N_W-1:0] n,
  input  logic signed [E_W-1:0] err,
  output logic        [A_W-1:0] a_nxt,
  output logic signed [B_W-1:0] b_nxt,
  output logic signed [C_W-1:0] c_nxt,
  output logic        [N_W-1:0] n_nxt,
  output logic                  halved
);

  localparam int A_MAX = (1 << A_W) - 1;

  logic signed [31:0] e_w;
  logic signed [31:0] a_w;
  logic signed [31:0] b_w;
  logic signed [31:0] c_w;
  logic signed [31:0] n_w;

  always_comb begin
    e_w    = 32'(err);
    a_w    = 32'(a) + ((e_w < 0) ? -e_w : e_w);
    b_w    = 32'(b) + e_w * (2 * NEAR + 1);
    c_w    = 32'(c);
    n_w    = 32'(n);
    halved = 1'b0;

    if (a_w > A_MAX) a_w = A_MAX;

    // Halving looks at the stored N, before the increment.
    if (n_w == RESET_TH) begin
      a_w    = a_w >>> 1;
      b_w    = b_w >>> 1;
      n_w    = n_w >>> 1;
      halved = 1'b1;
    end

    n_w = n_w + 1;

    // Bias correction keeps B in (-N, 0] and nudges C by one step.
    if (b_w <= -n_w) begin
      b_w = b_w + n_w;
      if (c_w > MIN_C) c_w = c_w - 1;
      if (b_w <= -n_w) b_w = 1 - n_w;
    end else if (b_w > 0) begin
      b_w = b_w - n_w;
      if (c_w < MAX_C) c_w = c_w + 1;
      if (b_w > 0) b_w = 0;
    end

    a_nxt = A_W'(a_w);
    b_nxt = B_W'(b_w);
    c_nxt = C_W'(c_w);
    n_nxt = N_W'(n_w);
  end

endmodule

// File: rtl/context_update.sv
// context_update: pipelined JPEG-LS regular-mode context update.
//   clk, rst            -- clock, asynchronous active-high reset
//   in_valid/in_ready   -- request handshake; in_ctx, in_err carry the request
//   out_valid           -- one-cycle strobe, 2 cycles after acceptance
//   out_ctx, out_A/B/C/N, out_reset -- post-update context and halving flag
//   dbg_state           -- initialisation FSM state
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// in_ready depends only on the FSM state, never on in_valid. Requests whose
// in_ctx is not below CTX_NUM are dropped silently. The output side has no
// ready: out_valid is a strobe that must be consumed when it appears.
// Pipeline: accept edge -> RAM read into rd_data (stage 1) -> operands
// captured in stage 2, ctx_arith computes, RAM write and output registers
// load on the following edge.
module context_update
  import context_update_pkg::*;
#(
  parameter int CTX_NUM  = 365,
  parameter int N_W      = DEF_N_W,
  parameter int A_W      = DEF_A_W,
  parameter int B_W      = DEF_B_W,
  parameter int C_W      = DEF_C_W,
  parameter int E_W      = DEF_E_W,
  parameter int RESET_TH = 64,
  parameter int A_INIT   = 4,
  parameter int NEAR     = 0,
  localparam int CW      = (CTX_NUM > 1) ? $clog2(CTX_NUM) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic         [CW-1:0] in_ctx,
  input  logic signed [E_W-1:0] in_err,
  output logic                  out_valid,
  output logic         [CW-1:0] out_ctx,
  output logic        [A_W-1:0] out_A,
  output logic signed [B_W-1:0] out_B,
  output logic signed [C_W-1:0] out_C,
  output logic        [N_W-1:0] out_N,
  output logic                  out_reset,
  output ctx_state_e            dbg_state
);

  localparam int REC_W = A_W + B_W + C_W + N_W;
  localparam logic [CW-1:0]    LAST_CTX = CW'(CTX_NUM - 1);
  localparam logic [REC_W-1:0] INIT_REC = {A_W'(A_INIT), B_W'(0), C_W'(0), N_W'(1)};

  ctx_state_e state;
  logic [CW-1:0] init_cnt;

  logic [REC_W-1:0] mem [CTX_NUM];
  logic [REC_W-1:0] rd_data;

  logic                  s1_valid;
  logic         [CW-1:0] s1_ctx;
  logic signed [E_W-1:0] s1_err;

  logic                  s2_valid;
  logic         [CW-1:0] s2_ctx;
  logic signed [E_W-1:0] s2_err;
  logic        [A_W-1:0] s2_a;
  logic signed [B_W-1:0] s2_b;
  logic signed [C_W-1:0] s2_c;
  logic        [N_W-1:0] s2_n;

  logic        [A_W-1:0] x_a;
  logic signed [B_W-1:0] x_b;
  logic signed [C_W-1:0] x_c;
  logic        [N_W-1:0] x_n;
  logic                  x_halved;

  logic             accept;
  logic [REC_W-1:0] fwd;
  logic             wr_en;
  logic [CW-1:0]    wr_addr;
  logic [REC_W-1:0] wr_data;

  assign in_ready  = (state == ST_RUN);
  assign dbg_state = state;
  assign accept    = in_valid && in_ready && (in_ctx <= LAST_CTX);

  ctx_arith #(
    .N_W(N_W), .A_W(A_W), .B_W(B_W), .C_W(C_W), .E_W(E_W),
    .RESET_TH(RESET_TH), .NEAR(NEAR)
  ) u_arith (
    .a(s2_a), .b(s2_b), .c(s2_c), .n(s2_n), .err(s2_err),
    .a_nxt(x_a), .b_nxt(x_b), .c_nxt(x_c), .n_nxt(x_n), .halved(x_halved)
  );

  // Stage-1 operand select. The stage-2 result is newest. The output
  // registers hold the record written on the same edge the RAM was read,
  // which the read-before-write RAM could not yet return.
  always_comb begin
    fwd = rd_data;
    if (s2_valid && (s2_ctx == s1_ctx))
      fwd = {x_a, x_b, x_c, x_n};
    else if (out_valid && (out_ctx == s1_ctx))
      fwd = {out_A, out_B, out_C, out_N};
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = s2_ctx;
    wr_data = {x_a, x_b, x_c, x_n};
    if (state == ST_INIT) begin
      wr_en   = 1'b1;
      wr_addr = init_cnt;
      wr_data = INIT_REC;
    end else if (s2_valid) begin
      wr_en = 1'b1;
    end
  end

  // Context store: one read port, one write port, no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (accept) rd_data <= mem[in_ctx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      s1_valid  <= 1'b0;
      s1_ctx    <= '0;
      s1_err    <= '0;
      s2_valid  <= 1'b0;
      s2_ctx    <= '0;
      s2_err    <= '0;
      s2_a      <= '0;
      s2_b      <= '0;
      s2_c      <= '0;
      s2_n      <= '0;
      out_valid <= 1'b0;
      out_reset <= 1'b0;
      out_ctx   <= '0;
      out_A     <= '0;
      out_B     <= '0;
      out_C     <= '0;
      out_N     <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == LAST_CTX) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase

      s1_valid <= accept;
      if (accept) begin
        s1_ctx <= in_ctx;
        s1_err <= in_err;
      end

      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_ctx <= s1_ctx;
        s2_err <= s1_err;
        {s2_a, s2_b, s2_c, s2_n} <= fwd;
      end

      out_valid <= s2_valid;
      out_reset <= s2_valid && x_halved;
      if (s2_valid) begin
        out_ctx <= s2_ctx;
        out_A   <= x_a;
        out_B   <= x_b;
        out_C   <= x_c;
        out_N   <= x_n;
      end
    end
  end

endmodule

// File: tb/tb_context_update.sv
// Bench for context_update: directed steps plus random traffic, checked
// against an integer reference model of the context update rules.
module tb_context_update;
  import context_update_pkg::*;

  localparam int CTX_NUM = 365;
  localparam int CW      = 9;
  localparam int NEAR    = 0;
  localparam int RW      = 1 + CW + 1 + 16 + 16 + 8 + 7;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic      [CW-1:0] in_ctx;
  logic signed  [8:0] in_err;
  logic               out_valid;
  logic      [CW-1:0] out_ctx;
  logic        [15:0] out_A;
  logic signed [15:0] out_B;
  logic signed  [7:0] out_C;
  logic         [6:0] out_N;
  logic               out_reset;
  ctx_state_e         dbg_state;

  int tests = 0;
  int fails = 0;

  // Reference context store
  int m_a [CTX_NUM];
  int m_b [CTX_NUM];
  int m_c [CTX_NUM];
  int m_n [CTX_NUM];

  logic [RW-1:0] exp_q[$];
  bit ready_exp;

  int last_a, last_b, last_c, last_n, last_reset, last_ctx;

  context_update dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctx(in_ctx), .in_err(in_err),
    .out_valid(out_valid), .out_ctx(out_ctx),
    .out_A(out_A), .out_B(out_B), .out_C(out_C), .out_N(out_N),
    .out_reset(out_reset), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < CTX_NUM; i++) begin
      m_a[i] = 4;
      m_b[i] = 0;
      m_c[i] = 0;
      m_n[i] = 1;
    end
  endfunction

  // Serial reference: applies one update and returns the expected record.
  function automatic logic [RW-1:0] model_update(input int ctx, input int err);
    int a, b, c, n;
    bit rs;
    a  = m_a[ctx] + ((err < 0) ? -err : err);
    if (a > 65535) a = 65535;
    b  = m_b[ctx] + err * (2 * NEAR + 1);
    c  = m_c[ctx];
    n  = m_n[ctx];
    rs = 1'b0;
    if (n == 64) begin
      a  = a / 2;
      b  = (b < 0) ? -((-b + 1) / 2) : b / 2;  // floor(b/2)
      n  = n / 2;
      rs = 1'b1;
    end
    n = n + 1;
    if (b <= -n) begin
      b = b + n;
      if (c > MIN_C) c = c - 1;
      if (b <= -n) b = 1 - n;
    end else if (b > 0) begin
      b = b - n;
      if (c < MAX_C) c = c + 1;
      if (b > 0) b = 0;
    end
    m_a[ctx] = a;
    m_b[ctx] = b;
    m_c[ctx] = c;
    m_n[ctx] = n;
    return {1'b1, CW'(ctx), rs, 16'(a), 16'(b), 8'(c), 7'(n)};
  endfunction

  // Driver: one cycle of stimulus, then checks the output due this cycle.
  task automatic tick(input bit v, input int ctx, input int err);
    logic [RW-1:0] e;
    logic [RW-1:0] o;
    in_valid = v;
    in_ctx   = CW'(ctx);
    in_err   = 9'(err);
    if (v && ready_exp && ctx < CTX_NUM) exp_q.push_back(model_update(ctx, err));
    else exp_q.push_back('0);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    o = {out_valid, out_ctx, out_reset, out_A, out_B, out_C, out_N};
    if (e[RW-1]) check("out_record", 64'(o), 64'(e));
    else check("out_idle", 64'(out_valid), 64'(0));
    check("in_ready", 64'(in_ready), 64'(ready_exp));
    if (out_valid) begin
      last_a     = int'(out_A);
      last_b     = int'(out_B);
      last_c     = int'(out_C);
      last_n     = int'(out_N);
      last_reset = int'(out_reset);
      last_ctx   = int'(out_ctx);
    end
    in_valid = 1'b0;
  endtask

  task automatic prime();
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('0);
    ready_exp = 1'b1;
  endtask

  task automatic drain();
    repeat (3) tick(1'b0, 0, 0);
  endtask

  // Waits (bounded) for in_ready, counting edges and noting any out_valid.
  task automatic wait_init(output int cnt, output bit saw_ov);
    cnt    = 0;
    saw_ov = 1'b0;
    while (!in_ready && cnt < 1000) begin
      @(posedge clk);
      #1;
      cnt++;
      if (out_valid) saw_ov = 1'b1;
    end
  endtask

  initial begin
    int  cnt;
    bit  saw_ov;
    bit  v;
    int  ctx, err;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_ctx    = '0;
    in_err    = '0;
    ready_exp = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_A", 64'(out_A), 64'(0));
    check("rst_out_N", 64'(out_N), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(ST_INIT));

    // Initialisation length
    @(negedge clk);
    rst = 1'b0;
    wait_init(cnt, saw_ov);
    check("init_cycles", 64'(cnt), 64'(CTX_NUM));
    check("init_no_out", 64'(saw_ov), 64'(0));
    check("run_state", 64'(dbg_state), 64'(ST_RUN));
    model_reset();
    prime();

    // First update: ctx 5, err 0
    tick(1'b1, 5, 0);
    drain();
    check("first_A", 64'(last_a), 64'(4));
    check("first_B", 64'(last_b), 64'(0));
    check("first_C", 64'(last_c), 64'(0));
    check("first_N", 64'(last_n), 64'(2));

    // Halving: 63 back-to-back updates, then the 64th
    repeat (63) tick(1'b1, 3, 1);
    tick(1'b1, 3, 1);
    drain();
    check("halve_reset", 64'(last_reset), 64'(1));
    check("halve_N", 64'(last_n), 64'(33));

    // Negative bias step on ctx 7
    tick(1'b1, 7, -3);
    drain();
    check("neg_A", 64'(last_a), 64'(7));
    check("neg_B", 64'(last_b), 64'(-1));
    check("neg_C", 64'(last_c), 64'(-1));
    check("neg_N", 64'(last_n), 64'(2));

    // Back-to-back same context, then a one-cycle gap
    repeat (4) tick(1'b1, 9, 2);
    tick(1'b1, 11, 5);
    tick(1'b0, 0, 0);
    tick(1'b1, 11, -7);
    tick(1'b1, 12, 3);
    tick(1'b1, 11, 4);
    drain();
    check("fwd_ctx", 64'(last_ctx), 64'(11));

    // C saturation at both limits
    repeat (200) tick(1'b1, 20, 100);
    drain();
    check("c_max", 64'(last_c), 64'(127));
    repeat (200) tick(1'b1, 30, -256);
    drain();
    check("c_min", 64'(last_c), 64'(-128));

    // Out-of-range context is ignored
    tick(1'b1, 400, 10);
    tick(1'b1, 511, -10);
    drain();

    // Random traffic on a few contexts to provoke hazards
    repeat (400) begin
      v   = ($urandom_range(0, 9) < 7);
      ctx = ($urandom_range(0, 19) == 0) ? int'($urandom_range(365, 511))
                                         : int'($urandom_range(0, 15));
      err = int'($urandom_range(0, 511)) - 256;
      tick(v, ctx, err);
    end
    drain();

    // Reset with two requests in flight
    tick(1'b1, 3, 5);
    tick(1'b1, 4, 7);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(0));
    check("mid_rst_out_A", 64'(out_A), 64'(0));
    check("mid_rst_out_B", 64'(out_B), 64'(0));
    check("mid_rst_out_reset", 64'(out_reset), 64'(0));
    check("mid_rst_state", 64'(dbg_state), 64'(ST_INIT));
    repeat (2) begin
      @(posedge clk);
      #1;
      check("in_rst_out_valid", 64'(out_valid), 64'(0));
    end
    @(negedge clk);
    rst       = 1'b0;
    ready_exp = 1'b0;
    wait_init(cnt, saw_ov);
    check("reinit_cycles", 64'(cnt), 64'(CTX_NUM));
    check("reinit_no_out", 64'(saw_ov), 64'(0));
    model_reset();
    prime();
    tick(1'b1, 4, 0);
    tick(1'b1, 3, 0);
    drain();
    check("reinit_ctx", 64'(last_ctx), 64'(3));
    check("reinit_A", 64'(last_a), 64'(4));
    check("reinit_B", 64'(last_b), 64'(0));
    check("reinit_C", 64'(last_c), 64'(0));
    check("reinit_N", 64'(last_n), 64'(2));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
